// File: rtl/snn_cmd_pkg.sv
// Shared types and helpers for the SNN command decoder.
package snn_cmd_pkg;

  localparam int NUM_CMDS_DEF = 10;
  localparam int CMD_ID_W     = 4;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    SCAN  = 2'd1,
    HOLD  = 2'd2
  } state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/snn_cmd_counter_bank.sv
// Bank of NUM_CMDS saturating spike counters with synchronous clear and
// an indexed read port used by the sequential argmax.
module snn_cmd_counter_bank
  import snn_cmd_pkg::*;
#(
  parameter int NUM_CMDS = NUM_CMDS_DEF,
  parameter int CNT_W    = 8,
  parameter int IDX_W    = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clr_i,
  input  logic [NUM_CMDS-1:0] inc_i,
  input  logic [IDX_W-1:0]    rd_idx_i,
  output logic [CNT_W-1:0]    rd_cnt_o
);

  localparam logic [31:0] MAX_V = 32'((64'd1 << CNT_W) - 64'd1);

  logic [NUM_CMDS-1:0][CNT_W-1:0] cnt_w;

  for (genvar i = 0; i < NUM_CMDS; i++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;
    always_ff @(posedge clk) begin
      if (!reset_n || clr_i) cnt_q <= '0;
      else if (inc_i[i])     cnt_q <= CNT_W'(sat_inc(32'(cnt_q), MAX_V));
    end
    assign cnt_w[i] = cnt_q;
  end

  assign rd_cnt_o = (32'(rd_idx_i) < 32'(NUM_CMDS)) ? cnt_w[rd_idx_i] : '0;

endmodule

// File: rtl/snn_cmd_decoder.sv
// Windowed spike-count accumulator + sequential argmax for SNN commands.
// Optional CMD_MARGIN_EN adds a best-minus-second margin output and rule.
module snn_cmd_decoder
  import snn_cmd_pkg::*;
#(
  parameter int NUM_CMDS     = NUM_CMDS_DEF,
  parameter int WINDOW_STEPS = 64,
  parameter int CNT_W        = 8,
  parameter int MIN_SPIKES   = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_CMDS-1:0] cmd_spikes,
  input  logic                spikes_valid,
  output logic                cmd_valid,
  input  logic                cmd_ready,
  output logic [CMD_ID_W-1:0] cmd_id,
  output logic [CNT_W-1:0]    cmd_count,
  output logic                cmd_none,
  output logic                busy,
  output logic                beats_dropped
`ifdef CMD_MARGIN_EN
  ,
  output logic [CNT_W-1:0]    cmd_margin
`endif
);

  localparam int STEP_W = $clog2(WINDOW_STEPS + 1);
  localparam int IDX_W  = (NUM_CMDS > 1) ? $clog2(NUM_CMDS) : 1;

  state_e              state_q;
  logic [STEP_W-1:0]   step_q;
  logic [IDX_W-1:0]    idx_q;
  logic [CNT_W-1:0]    best_cnt_q, best_cnt_d;
  logic [IDX_W-1:0]    best_id_q, best_id_d;
  logic                cmd_valid_q, cmd_none_q, busy_q, drop_q;
  logic [CMD_ID_W-1:0] cmd_id_q;
  logic [CNT_W-1:0]    cmd_count_q;
  logic [CNT_W-1:0]    rd_cnt;
  logic [NUM_CMDS-1:0] inc;
  logic                clr;
  logic                gt_best;
  logic                none_d;

  assign inc = (state_q == ACCUM && spikes_valid) ? cmd_spikes : '0;
  assign clr = (state_q == HOLD) && cmd_ready;

  snn_cmd_counter_bank #(
    .NUM_CMDS (NUM_CMDS),
    .CNT_W    (CNT_W),
    .IDX_W    (IDX_W)
  ) u_bank (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr_i    (clr),
    .inc_i    (inc),
    .rd_idx_i (idx_q),
    .rd_cnt_o (rd_cnt)
  );

  // Strict compare keeps the earliest (lowest) index on ties.
  assign gt_best    = rd_cnt > best_cnt_q;
  assign best_cnt_d = gt_best ? rd_cnt : best_cnt_q;
  assign best_id_d  = gt_best ? idx_q  : best_id_q;

`ifdef CMD_MARGIN_EN
  logic [CNT_W-1:0] second_q, second_d, margin_d, cmd_margin_q;

  // A count equal to the best lands in second, so ties give margin 0.
  assign second_d = gt_best ? best_cnt_q : ((rd_cnt > second_q) ? rd_cnt : second_q);
  assign margin_d = best_cnt_d - second_d;
  assign none_d   = (32'(best_cnt_d) < 32'(MIN_SPIKES)) ||
                    (32'(margin_d) < 32'(MIN_SPIKES / 2));
  assign cmd_margin = cmd_margin_q;
`else
  assign none_d = 32'(best_cnt_d) < 32'(MIN_SPIKES);
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ACCUM;
      step_q      <= '0;
      idx_q       <= '0;
      best_cnt_q  <= '0;
      best_id_q   <= '0;
      cmd_valid_q <= 1'b0;
      cmd_none_q  <= 1'b0;
      cmd_id_q    <= '0;
      cmd_count_q <= '0;
      busy_q      <= 1'b0;
      drop_q      <= 1'b0;
`ifdef CMD_MARGIN_EN
      second_q     <= '0;
      cmd_margin_q <= '0;
`endif
    end else begin
      if (spikes_valid && state_q != ACCUM) drop_q <= 1'b1;
      case (state_q)
        ACCUM: begin
          if (spikes_valid) begin
            step_q <= step_q + 1'b1;
            if (step_q == STEP_W'(WINDOW_STEPS - 1)) begin
              state_q    <= SCAN;
              busy_q     <= 1'b1;
              idx_q      <= '0;
              best_cnt_q <= '0;
              best_id_q  <= '0;
`ifdef CMD_MARGIN_EN
              second_q   <= '0;
`endif
            end
          end
        end
        SCAN: begin
          best_cnt_q <= best_cnt_d;
          best_id_q  <= best_id_d;
`ifdef CMD_MARGIN_EN
          second_q   <= second_d;
`endif
          if (idx_q == IDX_W'(NUM_CMDS - 1)) begin
            state_q     <= HOLD;
            cmd_valid_q <= 1'b1;
            cmd_id_q    <= CMD_ID_W'(best_id_d);
            cmd_count_q <= best_cnt_d;
            cmd_none_q  <= none_d;
`ifdef CMD_MARGIN_EN
            cmd_margin_q <= margin_d;
`endif
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        HOLD: begin
          if (cmd_ready) begin
            cmd_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            step_q      <= '0;
            state_q     <= ACCUM;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign cmd_valid     = cmd_valid_q;
  assign cmd_id        = cmd_id_q;
  assign cmd_count     = cmd_count_q;
  assign cmd_none      = cmd_none_q;
  assign busy          = busy_q;
  assign beats_dropped = drop_q;

endmodule

// File: tb/tb_snn_cmd_decoder.sv
// Directed bench for snn_cmd_decoder; a CNT_W=4 copy covers saturation and,
// with CMD_MARGIN_EN, a MIN_SPIKES=8 copy covers the margin rule.
module tb_snn_cmd_decoder;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] spikes = '0;
  logic       spikes_valid = 1'b0;
  logic       cmd_ready = 1'b0;
  int         checks = 0;
  int         errors = 0;

  logic       m_valid, m_none, m_busy, m_drop;
  logic [3:0] m_id;
  logic [7:0] m_count;
  logic       s_valid, s_none, s_busy, s_drop;
  logic [3:0] s_id;
  logic [3:0] s_count;

  always #5 clk = ~clk;

  snn_cmd_decoder #(.NUM_CMDS(10), .WINDOW_STEPS(64), .CNT_W(8), .MIN_SPIKES(4)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_spikes(spikes), .spikes_valid(spikes_valid),
    .cmd_valid(m_valid), .cmd_ready(cmd_ready), .cmd_id(m_id), .cmd_count(m_count),
    .cmd_none(m_none), .busy(m_busy), .beats_dropped(m_drop)
`ifdef CMD_MARGIN_EN
    , .cmd_margin()
`endif
  );

  snn_cmd_decoder #(.NUM_CMDS(10), .WINDOW_STEPS(64), .CNT_W(4), .MIN_SPIKES(4)) dut_sat (
    .clk(clk), .reset_n(reset_n), .cmd_spikes(spikes), .spikes_valid(spikes_valid),
    .cmd_valid(s_valid), .cmd_ready(cmd_ready), .cmd_id(s_id), .cmd_count(s_count),
    .cmd_none(s_none), .busy(s_busy), .beats_dropped(s_drop)
`ifdef CMD_MARGIN_EN
    , .cmd_margin()
`endif
  );

`ifdef CMD_MARGIN_EN
  logic       g_valid, g_none, g_busy, g_drop;
  logic [3:0] g_id;
  logic [7:0] g_count, g_margin;

  snn_cmd_decoder #(.NUM_CMDS(10), .WINDOW_STEPS(64), .CNT_W(8), .MIN_SPIKES(8)) dut_mgn (
    .clk(clk), .reset_n(reset_n), .cmd_spikes(spikes), .spikes_valid(spikes_valid),
    .cmd_valid(g_valid), .cmd_ready(cmd_ready), .cmd_id(g_id), .cmd_count(g_count),
    .cmd_none(g_none), .busy(g_busy), .beats_dropped(g_drop), .cmd_margin(g_margin)
  );
`endif

  task automatic send_beat(input logic [9:0] s);
    spikes = s;
    spikes_valid = 1'b1;
    @(negedge clk);
    spikes_valid = 1'b0;
    spikes = '0;
  endtask

  // n1 beats of p1, then n2 beats of p2, then zero beats up to 64.
  task automatic send_window(input logic [9:0] p1, input int n1, input logic [9:0] p2, input int n2);
    for (int k = 0; k < 64; k++) begin
      if (k < n1)           send_beat(p1);
      else if (k < n1 + n2) send_beat(p2);
      else                  send_beat(10'h000);
    end
  endtask

  task automatic wait_decision(input string name);
    int n;
    n = 0;
    while (m_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 10) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles, expected 10", name, n);
    end
  endtask

  task automatic check_result(input string name, input logic [3:0] id, input logic [7:0] cnt, input logic none);
    checks++;
    if (m_valid !== 1'b1 || m_id !== id || m_count !== cnt || m_none !== none) begin
      errors++;
      $display("FAIL %s result: valid=%b id=%0d count=%0d none=%b, expected valid=1 id=%0d count=%0d none=%b",
               name, m_valid, m_id, m_count, m_none, id, cnt, none);
    end
  endtask

  task automatic handshake(input string name);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    checks++;
    if (m_valid !== 1'b0 || m_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s handshake: valid=%b busy=%b, expected 0 0", name, m_valid, m_busy);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || m_busy !== 1'b0 || m_drop !== 1'b0 || m_none !== 1'b0 ||
        m_id !== 4'd0 || m_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: valid=%b busy=%b drop=%b none=%b id=%0d count=%0d, expected all 0",
               m_valid, m_busy, m_drop, m_none, m_id, m_count);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    for (int k = 0; k < 64; k++) send_beat((k % 2 == 0) ? 10'h028 : 10'h008);
    checks++;
    if (m_busy !== 1'b1 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_scan_entry: busy=%b valid=%b, expected 1 0", m_busy, m_valid);
    end
    wait_decision("basic");
    check_result("basic", 4'd3, 8'd64, 1'b0);
`ifdef CMD_MARGIN_EN
    checks++;
    if (g_id !== 4'd3 || g_margin !== 8'd32 || g_none !== 1'b0) begin
      errors++;
      $display("FAIL basic_margin: id=%0d margin=%0d none=%b, expected 3 32 0", g_id, g_margin, g_none);
    end
`endif
    handshake("basic");
  endtask

  task automatic test_tie;
    send_window(10'h084, 10, 10'h000, 0);
    wait_decision("tie");
    check_result("tie", 4'd2, 8'd10, 1'b0);
`ifdef CMD_MARGIN_EN
    checks++;
    if (g_id !== 4'd2 || g_margin !== 8'd0 || g_none !== 1'b1) begin
      errors++;
      $display("FAIL tie_margin: id=%0d margin=%0d none=%b, expected 2 0 1", g_id, g_margin, g_none);
    end
`endif
    handshake("tie");
  endtask

  task automatic test_threshold;
    send_window(10'h200, 3, 10'h000, 0);
    wait_decision("threshold");
    check_result("threshold", 4'd9, 8'd3, 1'b1);
    handshake("threshold");
  endtask

  task automatic test_saturation;
    send_window(10'h001, 64, 10'h000, 0);
    wait_decision("saturation");
    check_result("saturation_w8", 4'd0, 8'd64, 1'b0);
    checks++;
    if (s_valid !== 1'b1 || s_id !== 4'd0 || s_count !== 4'd15 || s_none !== 1'b0) begin
      errors++;
      $display("FAIL saturation_w4: valid=%b id=%0d count=%0d none=%b, expected 1 0 15 0",
               s_valid, s_id, s_count, s_none);
    end
    handshake("saturation");
  endtask

  task automatic test_backpressure;
    checks++;
    if (m_drop !== 1'b0) begin
      errors++;
      $display("FAIL drop_initial: beats_dropped=%b, expected 0", m_drop);
    end
    send_window(10'h040, 64, 10'h000, 0);
    wait_decision("bp");
    for (int c = 0; c < 20; c++) begin
      spikes = 10'h3FF;
      spikes_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b1 || m_id !== 4'd6 || m_count !== 8'd64 || m_none !== 1'b0) begin
        errors++;
        $display("FAIL bp_stable cycle %0d: valid=%b id=%0d count=%0d, expected 1 6 64", c, m_valid, m_id, m_count);
      end
    end
    checks++;
    if (m_drop !== 1'b1) begin
      errors++;
      $display("FAIL bp_dropped: beats_dropped=%b, expected 1", m_drop);
    end
    handshake("bp");
    spikes_valid = 1'b0;
    spikes = '0;
    send_window(10'h100, 5, 10'h000, 0);
    wait_decision("after_bp");
    check_result("after_bp", 4'd8, 8'd5, 1'b0);
    checks++;
    if (m_drop !== 1'b1) begin
      errors++;
      $display("FAIL drop_sticky: beats_dropped=%b, expected 1", m_drop);
    end
    handshake("after_bp");
  endtask

  task automatic test_reset_mid;
    send_window(10'h004, 64, 10'h000, 0);
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || m_busy !== 1'b0 || m_drop !== 1'b0 || m_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid: valid=%b busy=%b drop=%b count=%0d, expected 0 0 0 0",
               m_valid, m_busy, m_drop, m_count);
    end
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || m_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_idle: valid=%b busy=%b, expected 0 0", m_valid, m_busy);
    end
    send_window(10'h080, 7, 10'h000, 0);
    wait_decision("after_reset");
    check_result("after_reset", 4'd7, 8'd7, 1'b0);
    handshake("after_reset");
  endtask

`ifdef CMD_MARGIN_EN
  task automatic test_margin;
    send_window(10'h012, 18, 10'h002, 2);
    wait_decision("margin");
    check_result("margin_main", 4'd1, 8'd20, 1'b0);
    checks++;
    if (g_valid !== 1'b1 || g_id !== 4'd1 || g_count !== 8'd20 || g_margin !== 8'd2 || g_none !== 1'b1) begin
      errors++;
      $display("FAIL margin: valid=%b id=%0d count=%0d margin=%0d none=%b, expected 1 1 20 2 1",
               g_valid, g_id, g_count, g_margin, g_none);
    end
    handshake("margin");
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_tie;
    test_threshold;
    test_saturation;
    test_backpressure;
    test_reset_mid;
`ifdef CMD_MARGIN_EN
    test_margin;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/snn_cmd_decoder.md
Name: snn_cmd_decoder

Overview:
- Stage directly downstream of the SNN core.
- Consumes the core's 10-bit per-timestep command spike vector and its valid strobe.
- Accumulates per-command spike counts over a fixed window of timesteps, then runs a sequential argmax.
- Presents the winning command ID, with its count, on a valid/ready handshake to the host/command interface.

Parameters:
- NUM_CMDS, 10, number of command classes; equals command vector width.
- WINDOW_STEPS, 64, accepted timesteps per decision window (>=1).
- CNT_W, 8, per-class counter width; counters saturate.
- MIN_SPIKES, 4, minimum winning count for a valid command; below it, cmd_none asserts.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- reset_n  in  1  reset, synchronous, active-low.
- cmd_spikes  in  NUM_CMDS  per-timestep command spikes from the SNN core.
- spikes_valid  in  1  cmd_spikes qualifier; one beat = one timestep; no backpressure upstream.
- cmd_valid  out  1  decision available.
- cmd_ready  in  1  consumer accepts decision.
- cmd_id  out  4  winning class index.
- cmd_count  out  CNT_W  spike count of the winner.
- cmd_none  out  1  winner count < MIN_SPIKES; cmd_id is still reported.
- busy  out  1  high in SCAN or HOLD.
- beats_dropped  out  1  sticky; set when a beat arrives outside ACCUM; cleared only by reset.

Behaviour:
- Reset (reset_n low at a rising edge):
  - state = ACCUM; all counters, step counter and scan index = 0.
  - cmd_valid, cmd_none, busy, beats_dropped = 0; cmd_id = 0, cmd_count = 0.
  - Reset mid-SCAN or mid-HOLD discards the window and any pending decision.
- ACCUM:
  - Each edge with spikes_valid=1 increments count[i] for every i with cmd_spikes[i]=1, saturating at 2^CNT_W-1, and increments the step counter.
  - Zero-spike beats still count as a step.
  - The edge accepting beat number WINDOW_STEPS includes that beat's spikes, then moves to SCAN with scan_idx=0, best_cnt=0, best_id=0.
- SCAN:
  - One class per cycle. If count[scan_idx] > best_cnt (strict), update best_cnt/best_id.
  - Ties resolve to the lowest index; all-zero counts yield id 0, count 0.
  - After scan_idx=NUM_CMDS-1 is evaluated: state = HOLD; cmd_id, cmd_count and cmd_none are registered; cmd_valid=1.
  - Latency: cmd_valid is first high NUM_CMDS cycles after the edge that accepted the final beat.
- HOLD:
  - cmd_valid and the outputs stay stable until an edge with cmd_ready=1.
  - That edge: cmd_valid=0, counters and step counter cleared, state = ACCUM.
  - A beat on the same edge as the handshake is dropped (state was HOLD).
  - cmd_ready while cmd_valid=0 has no effect.
- Drops: spikes_valid=1 in SCAN or HOLD sets beats_dropped; counters are unchanged.
- Widths:
  - Step counter is clog2(WINDOW_STEPS+1) bits.
  - cmd_id is zero-extended to 4 bits.
  - The comparison is unsigned CNT_W.

Optional Feature:
- CMD_MARGIN_EN
  - Defined:
    - SCAN also tracks the second-best count.
    - Adds output port cmd_margin [CNT_W-1:0] = best − second, registered with cmd_valid.
    - cmd_none also asserts when margin < MIN_SPIKES/2 (integer division).
    - Ties give margin 0.
  - Undefined: no cmd_margin port and no second-best logic; cmd_none uses the count rule only.

Decomposition:
- Package snn_cmd_pkg:
  - NUM_CMDS_DEF=10 and CMD_ID_W=4.
  - State enum {ACCUM, SCAN, HOLD}.
  - Saturating-increment function.
- Sub-module snn_cmd_counter_bank: NUM_CMDS saturating counters with increment vector, synchronous clear, and read mux by index.
- FSM and argmax stay in the top.

Test Plan:
- Basic window: WINDOW_STEPS=64, 64 beats with bit 3 set every beat and bit 5 on even beats → cmd_id=3, cmd_count=64, cmd_none=0; cmd_valid rises exactly 10 cycles after the final beat.
- Tie: equal counts of 10 on classes 2 and 7 → cmd_id=2, cmd_count=10.
- Threshold and saturation:
  - Only class 9 spikes, 3 times → cmd_id=9, cmd_count=3, cmd_none=1.
  - CNT_W=4 with 64 beats on class 0 → cmd_count=15.
- Backpressure and drops:
  - Hold cmd_ready=0 for 20 cycles while driving beats → outputs stable, beats_dropped=1.
  - After the handshake, the next window starts from zero counts.
- Reset mid-operation: assert reset_n=0 in SCAN (idx=4) → next cycle cmd_valid=0, busy=0, counts 0; a fresh 64-beat window decodes correctly.
- CMD_MARGIN_EN: counts class1=20 and class4=18 with MIN_SPIKES=8 → cmd_id=1, cmd_margin=2, cmd_none=1.
